// File: rtl/led_pkg.sv
// Shared widths and enums for the rotating LED-segment monitor.
package led_pkg;

    localparam int LED_W  = 16;
    localparam int LEN_W  = 5;
    localparam int HEAD_W = 4;

    // Lock state of the monitor.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    // How a well-formed frame relates to the stored reference frame.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        ADVANCE = 2'd1,
        ILLEGAL = 2'd2
    } cls_e;

endpackage

// File: rtl/led_ring_decode.sv
// Combinational decoder for one LED frame: segment length, head position and
// whether the lit bits form exactly one contiguous run around the ring.
module led_ring_decode
    import led_pkg::*;
(
    input  logic [LED_W-1:0]  led,
    output logic [LEN_W-1:0]  len,
    output logic [HEAD_W-1:0] head,
    output logic              well_formed
);

    logic [LEN_W-1:0] n_heads;

    // Count lit bits and falling edges (lit bit followed by a dark neighbour);
    // a single falling edge means a single circular run, and it marks the head.
    always_comb begin
        len     = '0;
        head    = '0;
        n_heads = '0;
        for (int i = 0; i < LED_W; i++) begin
            len = len + LEN_W'(led[i]);
            if (led[i] && !led[(i + 1) % LED_W]) begin
                n_heads = n_heads + LEN_W'(1);
                head    = HEAD_W'(i);
            end
        end
        well_formed = (n_heads == LEN_W'(1)) && (len != '0) && (len != LEN_W'(LED_W));
    end

endmodule

// File: rtl/led_ring_monitor.sv
// Observer for the rotating LED-segment bus: decodes each sampled frame,
// checks for legal one-step rotation, tracks lock and counts locked advances.
// Handshake: there is no back-pressure; a frame is consumed on every rising
// edge where sample is high, and ignored otherwise.
module led_ring_monitor
    import led_pkg::*;
#(
    parameter int LOCK_COUNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [15:0] led,
    output logic [4:0]  seg_len,
    output logic [3:0]  seg_head,
    output logic        locked,
    output logic [15:0] step_cnt,
    output logic        err
);

    localparam logic [4:0] LOCK_THRESH = 5'(LOCK_COUNT);

    logic [LEN_W-1:0]  dec_len;
    logic [HEAD_W-1:0] dec_head;
    logic              dec_wf;
    cls_e              cls;

    state_e            state_q, state_d;
    logic              have_ref_q, have_ref_d;
    logic [LEN_W-1:0]  ref_len_q, ref_len_d;
    logic [HEAD_W-1:0] ref_head_q, ref_head_d;
    logic [3:0]        acq_q, acq_d;
    logic [LEN_W-1:0]  seg_len_q, seg_len_d;
    logic [HEAD_W-1:0] seg_head_q, seg_head_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic              err_q, err_d;

    led_ring_decode u_decode (
        .led         (led),
        .len         (dec_len),
        .head        (dec_head),
        .well_formed (dec_wf)
    );

    // Classify the incoming frame against the stored reference.
    always_comb begin
        cls = ILLEGAL;
        if (dec_len == ref_len_q) begin
            if (dec_head == ref_head_q) begin
                cls = HOLD;
            end else if (dec_head == ref_head_q + HEAD_W'(1)) begin
                cls = ADVANCE;
            end
        end
    end

    // State register for the lock FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update for one sampled frame.
    always_comb begin
        state_d    = state_q;
        have_ref_d = have_ref_q;
        ref_len_d  = ref_len_q;
        ref_head_d = ref_head_q;
        acq_d      = acq_q;
        seg_len_d  = seg_len_q;
        seg_head_d = seg_head_q;
        step_cnt_d = step_cnt_q;
        err_d      = 1'b0;
        if (sample) begin
            if (!dec_wf) begin
                // Malformed frame: flag it and restart acquisition from scratch.
                err_d      = 1'b1;
                have_ref_d = 1'b0;
                acq_d      = '0;
                state_d    = UNLOCKED;
            end else begin
                seg_len_d  = dec_len;
                seg_head_d = dec_head;
                if (!have_ref_q) begin
                    have_ref_d = 1'b1;
                    ref_len_d  = dec_len;
                    ref_head_d = dec_head;
                    acq_d      = '0;
                end else begin
                    case (cls)
                        HOLD: begin
                        end
                        ADVANCE: begin
                            ref_head_d = dec_head;
                            if (state_q == LOCKED) begin
                                step_cnt_d = step_cnt_q + 16'd1;
                            end else begin
                                acq_d = acq_q + 4'd1;
                                if ({1'b0, acq_q} + 5'd1 == LOCK_THRESH) begin
                                    state_d = LOCKED;
                                end
                            end
                        end
                        default: begin
                            // Only a locked monitor treats a broken rotation as an error.
                            if (state_q == LOCKED) begin
                                err_d = 1'b1;
                            end
                            state_d    = UNLOCKED;
                            ref_len_d  = dec_len;
                            ref_head_d = dec_head;
                            acq_d      = '0;
                        end
                    endcase
                end
            end
        end
    end

    // Reference, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_ref_q <= 1'b0;
            ref_len_q  <= '0;
            ref_head_q <= '0;
            acq_q      <= '0;
            seg_len_q  <= '0;
            seg_head_q <= '0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            have_ref_q <= have_ref_d;
            ref_len_q  <= ref_len_d;
            ref_head_q <= ref_head_d;
            acq_q      <= acq_d;
            seg_len_q  <= seg_len_d;
            seg_head_q <= seg_head_d;
            step_cnt_q <= step_cnt_d;
            err_q      <= err_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        locked   = (state_q == LOCKED);
        seg_len  = seg_len_q;
        seg_head = seg_head_q;
        step_cnt = step_cnt_q;
        err      = err_q;
    end

endmodule
